// File: rtl/edge_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : edge_frame_scheduler
// Brief    : Admits whole camera frames into the Sobel detector, sequences
//            threshold updates on frame boundaries and reports per-frame
//            edge statistics over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module edge_frame_scheduler #(
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int THR_DEFAULT = 450,
    parameter int CNT_W       = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_start,
    input  logic             cmd_mode,
    input  logic             cmd_stop,
    input  logic [10:0]      cfg_thr,
    input  logic             cfg_thr_wr,
    input  logic             src_vsync,
    input  logic             src_href,
    input  logic             src_clken,
    output logic             det_vsync,
    output logic             det_href,
    output logic             det_clken,
    output logic [10:0]      det_thr,
    input  logic             edge_vsync,
    input  logic             edge_href,
    input  logic             edge_clken,
    input  logic             edge_bit,
    output logic             stat_valid,
    input  logic             stat_ready,
    output logic [CNT_W-1:0] stat_edge_cnt,
    output logic [CNT_W-1:0] stat_pix_cnt,
    output logic             stat_err,
    output logic             stat_ovf,
    output logic             busy
);

    localparam int               COL_W   = $clog2(IMG_W + 1);
    localparam int               LINE_W  = $clog2(IMG_H + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [COL_W-1:0] COL_MAX = {COL_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t              state_q;
    logic                mode_q;
    logic                stop_pend_q;
    logic                gate_q;
    logic                inflight_q;
    logic [10:0]         shadow_q;
    logic [10:0]         thr_q;
    logic                src_vs_q;
    logic                det_vsync_q;
    logic                det_href_q;
    logic                det_clken_q;

    logic                edge_href_q;
    logic                edge_vs_q;
    logic [COL_W-1:0]    col_q;
    logic [LINE_W-1:0]   line_q;
    logic [CNT_W-1:0]    pix_q;
    logic [CNT_W-1:0]    edge_q;
    logic                err_q;

    logic                stat_valid_q;
    logic [CNT_W-1:0]    stat_edge_q;
    logic [CNT_W-1:0]    stat_pix_q;
    logic                stat_err_q;
    logic                stat_ovf_q;

    logic                w_fs;
    logic [10:0]         w_shadow;
    logic                w_pix;
    logic                w_eol;
    logic                w_efs;
    logic                w_line_bad;
    logic                w_done_norm;
    logic                w_done_early;
    logic                w_done;
    logic                w_accept;

    assign w_fs     = src_vsync & ~src_vs_q;
    // A write landing on the frame-start cycle must reach that frame.
    assign w_shadow = cfg_thr_wr ? cfg_thr : shadow_q;

    assign w_pix        = edge_href & edge_clken;
    assign w_eol        = edge_href_q & ~edge_href;
    assign w_efs        = edge_vsync & ~edge_vs_q;
    assign w_line_bad   = w_eol && (col_q != COL_W'(IMG_W));
    assign w_done_norm  = w_eol && (line_q == LINE_W'(IMG_H - 1));
    assign w_done_early = w_efs && (line_q != '0) && !w_done_norm;
    assign w_done       = w_done_norm | w_done_early;
    assign w_accept     = stat_valid_q & stat_ready;

    assign det_vsync     = det_vsync_q;
    assign det_href      = det_href_q;
    assign det_clken     = det_clken_q;
    assign det_thr       = thr_q;
    assign stat_valid    = stat_valid_q;
    assign stat_edge_cnt = stat_edge_q;
    assign stat_pix_cnt  = stat_pix_q;
    assign stat_err      = stat_err_q;
    assign stat_ovf      = stat_ovf_q;
    assign busy          = (state_q != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_vs_q    <= 1'b0;
            det_vsync_q <= 1'b0;
            det_href_q  <= 1'b0;
            det_clken_q <= 1'b0;
        end else begin
            src_vs_q    <= src_vsync;
            det_vsync_q <= src_vsync;
            det_href_q  <= src_href & gate_q;
            det_clken_q <= src_clken & gate_q;
        end
    end

    // Frame admission FSM; gate and det_thr only move on a frame-start cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            gate_q      <= 1'b0;
            inflight_q  <= 1'b0;
            shadow_q    <= 11'(THR_DEFAULT);
            thr_q       <= 11'(THR_DEFAULT);
        end else begin
            if (cfg_thr_wr) begin
                shadow_q <= cfg_thr;
            end
            if (w_done) begin
                inflight_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (cmd_start && !cmd_stop) begin
                        state_q <= ST_ARMED;
                        mode_q  <= cmd_mode;
                    end
                end
                ST_ARMED: begin
                    if (cmd_stop) begin
                        state_q <= ST_IDLE;
                    end else if (w_fs) begin
                        gate_q     <= 1'b1;
                        thr_q      <= w_shadow;
                        inflight_q <= 1'b1;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_fs) begin
                        if (!mode_q || stop_pend_q || cmd_stop) begin
                            gate_q      <= 1'b0;
                            stop_pend_q <= 1'b0;
                            state_q     <= ST_DRAIN;
                        end else begin
                            thr_q      <= w_shadow;
                            inflight_q <= 1'b1;
                        end
                    end else if (cmd_stop) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // The last admitted frame may already have completed before the closing FS.
                    if (!inflight_q || w_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_href_q <= 1'b0;
            edge_vs_q   <= 1'b0;
            col_q       <= '0;
            line_q      <= '0;
            pix_q       <= '0;
            edge_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            edge_href_q <= edge_href;
            edge_vs_q   <= edge_vsync;
            if (w_done || w_efs) begin
                col_q  <= '0;
                line_q <= '0;
                pix_q  <= '0;
                edge_q <= '0;
                err_q  <= 1'b0;
            end else if (w_pix) begin
                if (pix_q != CNT_MAX) begin
                    pix_q <= pix_q + CNT_W'(1);
                end
                if (edge_bit && (edge_q != CNT_MAX)) begin
                    edge_q <= edge_q + CNT_W'(1);
                end
                if (col_q != COL_MAX) begin
                    col_q <= col_q + COL_W'(1);
                end
            end else if (w_eol) begin
                col_q  <= '0;
                line_q <= line_q + LINE_W'(1);
                if (w_line_bad) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

    // An accept in the same cycle as a snapshot frees the slot for it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_valid_q <= 1'b0;
            stat_edge_q  <= '0;
            stat_pix_q   <= '0;
            stat_err_q   <= 1'b0;
            stat_ovf_q   <= 1'b0;
        end else begin
            if (w_done && (!stat_valid_q || w_accept)) begin
                stat_valid_q <= 1'b1;
                stat_edge_q  <= edge_q;
                stat_pix_q   <= pix_q;
                stat_err_q   <= err_q | w_line_bad | w_done_early;
            end else if (w_accept) begin
                stat_valid_q <= 1'b0;
            end
            if (w_done && stat_valid_q && !w_accept) begin
                stat_ovf_q <= 1'b1;
            end else if (w_accept) begin
                stat_ovf_q <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_edge_frame_scheduler
// Brief    : Scoreboard bench for edge_frame_scheduler on an 8x4 image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_edge_frame_scheduler;

    localparam int IW  = 8;
    localparam int IH  = 4;
    localparam int CW  = 20;

    typedef struct packed {
        logic [CW-1:0] e;
        logic [CW-1:0] p;
        logic          err;
    } res_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_start, cmd_mode, cmd_stop;
    logic [10:0]   cfg_thr;
    logic          cfg_thr_wr;
    logic          src_vsync, src_href, src_clken, src_edge;
    logic          det_vsync, det_href, det_clken;
    logic [10:0]   det_thr;
    logic          edge_vsync, edge_href, edge_clken, edge_bit;
    logic          stat_valid, stat_ready;
    logic [CW-1:0] stat_edge_cnt, stat_pix_cnt;
    logic          stat_err, stat_ovf, busy;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t exp_q[$];
    res_t obs_q[$];
    logic [10:0] thr_mid_obs;

    always #5 clk = ~clk;

    edge_frame_scheduler #(
        .IMG_W(IW), .IMG_H(IH), .THR_DEFAULT(450), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_start(cmd_start), .cmd_mode(cmd_mode), .cmd_stop(cmd_stop),
        .cfg_thr(cfg_thr), .cfg_thr_wr(cfg_thr_wr),
        .src_vsync(src_vsync), .src_href(src_href), .src_clken(src_clken),
        .det_vsync(det_vsync), .det_href(det_href), .det_clken(det_clken),
        .det_thr(det_thr),
        .edge_vsync(edge_vsync), .edge_href(edge_href), .edge_clken(edge_clken),
        .edge_bit(edge_bit),
        .stat_valid(stat_valid), .stat_ready(stat_ready),
        .stat_edge_cnt(stat_edge_cnt), .stat_pix_cnt(stat_pix_cnt),
        .stat_err(stat_err), .stat_ovf(stat_ovf), .busy(busy)
    );

    // Detector stand-in: 3-cycle pass-through, edge flag travels with the pixel.
    logic       s_edge_d;
    logic [2:0] pv, ph, pc, pe;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_edge_d <= 1'b0;
            pv <= '0; ph <= '0; pc <= '0; pe <= '0;
        end else begin
            s_edge_d <= src_edge;
            pv <= {pv[1:0], det_vsync};
            ph <= {ph[1:0], det_href};
            pc <= {pc[1:0], det_clken};
            pe <= {pe[1:0], s_edge_d};
        end
    end
    assign edge_vsync = pv[2];
    assign edge_href  = ph[2];
    assign edge_clken = pc[2];
    assign edge_bit   = pe[2];

    always @(negedge clk) begin
        res_t r;
        #1;
        if (stat_valid === 1'b1 && stat_ready === 1'b1) begin
            r.e = stat_edge_cnt;
            r.p = stat_pix_cnt;
            r.err = stat_err;
            obs_q.push_back(r);
        end
    end

    task automatic tick(inout int n);
        @(negedge clk);
        if (det_href === 1'b1 && det_clken === 1'b1) n++;
    endtask

    task automatic send_frame(input int edges, input int short_line, input int mid_thr,
                              input int fs_thr, input bit stop_mid, input int abort_line,
                              output int det_pix);
        int k;
        int n;
        k = 0;
        n = 0;
        src_vsync = 1'b1;
        if (fs_thr >= 0) begin
            cfg_thr = 11'(fs_thr);
            cfg_thr_wr = 1'b1;
        end
        tick(n);
        cfg_thr_wr = 1'b0;
        tick(n);
        src_vsync = 1'b0;
        repeat (4) tick(n);
        for (int l = 0; l < IH; l++) begin
            if (l == abort_line) begin
                det_pix = n;
                return;
            end
            if (l == 1) begin
                if (mid_thr >= 0) begin
                    cfg_thr = 11'(mid_thr);
                    cfg_thr_wr = 1'b1;
                end
                if (stop_mid) cmd_stop = 1'b1;
                tick(n);
                cfg_thr_wr = 1'b0;
                cmd_stop = 1'b0;
                tick(n);
                thr_mid_obs = det_thr;
            end
            for (int p = 0; p < ((l == short_line) ? IW - 1 : IW); p++) begin
                src_href = 1'b1;
                src_clken = 1'b1;
                src_edge = (k < edges);
                k++;
                tick(n);
            end
            src_href = 1'b0;
            src_clken = 1'b0;
            src_edge = 1'b0;
            repeat (4) tick(n);
        end
        repeat (20) tick(n);
        det_pix = n;
    endtask

    task automatic push_exp(input int e, input int p, input bit err);
        res_t r;
        r.e = CW'(e);
        r.p = CW'(p);
        r.err = err;
        exp_q.push_back(r);
    endtask

    task automatic pulse_cmd(input bit start, input bit mode, input bit stop);
        cmd_start = start;
        cmd_mode = mode;
        cmd_stop = stop;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_stop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (det_vsync !== 1'b0) begin n_bad++; $display("FAIL reset_det_vsync: got %b want 0", det_vsync); end
        n_cmp++; if (det_href !== 1'b0) begin n_bad++; $display("FAIL reset_det_href: got %b want 0", det_href); end
        n_cmp++; if (det_clken !== 1'b0) begin n_bad++; $display("FAIL reset_det_clken: got %b want 0", det_clken); end
        n_cmp++; if (det_thr !== 11'd450) begin n_bad++; $display("FAIL reset_det_thr: got %0d want 450", det_thr); end
        n_cmp++; if (stat_valid !== 1'b0) begin n_bad++; $display("FAIL reset_stat_valid: got %b want 0", stat_valid); end
        n_cmp++; if (stat_err !== 1'b0 || stat_ovf !== 1'b0) begin n_bad++; $display("FAIL reset_err_ovf: got %b%b want 00", stat_err, stat_ovf); end
        n_cmp++; if (stat_edge_cnt !== '0 || stat_pix_cnt !== '0) begin n_bad++; $display("FAIL reset_counts: got %0d/%0d want 0/0", stat_edge_cnt, stat_pix_cnt); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single_shot();
        int dp;
        res_t o, e;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_armed: got %b want 1", busy); end
        push_exp(5, 32, 1'b0);
        send_frame(5, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (dp !== 32) begin n_bad++; $display("FAIL single_gated_pixels: got %0d want 32", dp); end
        send_frame(0, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (dp !== 0) begin n_bad++; $display("FAIL single_next_ungated: got %0d want 0", dp); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_idle_after_drain: got %b want 0", busy); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL single_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL single_result: got e=%0d p=%0d err=%0d want e=%0d p=%0d err=%0d", o.e, o.p, o.err, e.e, e.p, e.err); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_continuous_stop();
        int dp;
        res_t o, e;
        pulse_cmd(1'b1, 1'b1, 1'b0);
        push_exp(3, 32, 1'b0);
        send_frame(3, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (dp !== 32) begin n_bad++; $display("FAIL cont_frame1_gated: got %0d want 32", dp); end
        push_exp(7, 32, 1'b0);
        send_frame(7, -1, -1, -1, 1'b1, -1, dp);
        n_cmp++; if (dp !== 32) begin n_bad++; $display("FAIL cont_frame2_gated: got %0d want 32", dp); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL cont_busy_stop_pending: got %b want 1", busy); end
        send_frame(1, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (dp !== 0) begin n_bad++; $display("FAIL cont_frame3_ungated: got %0d want 0", dp); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL cont_busy_after_drain: got %b want 0", busy); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL cont_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL cont_result: got e=%0d p=%0d err=%0d want e=%0d p=%0d err=%0d", o.e, o.p, o.err, e.e, e.p, e.err); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_threshold();
        int dp;
        res_t o, e;
        pulse_cmd(1'b1, 1'b1, 1'b0);
        push_exp(0, 32, 1'b0);
        send_frame(0, -1, 300, -1, 1'b0, -1, dp);
        n_cmp++; if (thr_mid_obs !== 11'd450) begin n_bad++; $display("FAIL thr_mid_frame_hold: got %0d want 450", thr_mid_obs); end
        n_cmp++; if (det_thr !== 11'd450) begin n_bad++; $display("FAIL thr_before_fs: got %0d want 450", det_thr); end
        push_exp(0, 32, 1'b0);
        send_frame(0, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (det_thr !== 11'd300) begin n_bad++; $display("FAIL thr_after_fs: got %0d want 300", det_thr); end
        push_exp(0, 32, 1'b0);
        send_frame(0, -1, -1, 123, 1'b1, -1, dp);
        n_cmp++; if (thr_mid_obs !== 11'd123) begin n_bad++; $display("FAIL thr_write_on_fs: got %0d want 123", thr_mid_obs); end
        send_frame(0, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (busy !== 1'b0 || dp !== 0) begin n_bad++; $display("FAIL thr_stop_drain: got busy=%b pix=%0d want busy=0 pix=0", busy, dp); end
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL thr_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL thr_result: got e=%0d p=%0d err=%0d want e=%0d p=%0d err=%0d", o.e, o.p, o.err, e.e, e.p, e.err); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_geometry();
        int dp;
        res_t o, e;
        pulse_cmd(1'b1, 1'b0, 1'b0);
        push_exp(4, 31, 1'b1);
        send_frame(4, 2, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (dp !== 31) begin n_bad++; $display("FAIL geom_gated_pixels: got %0d want 31", dp); end
        send_frame(0, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL geom_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL geom_result: got e=%0d p=%0d err=%0d want e=%0d p=%0d err=%0d", o.e, o.p, o.err, e.e, e.p, e.err); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_overflow();
        int dp;
        res_t o, e;
        stat_ready = 1'b0;
        pulse_cmd(1'b1, 1'b1, 1'b0);
        push_exp(2, 32, 1'b0);
        send_frame(2, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (stat_valid !== 1'b1 || stat_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_first_held: got valid=%b ovf=%b want 1/0", stat_valid, stat_ovf); end
        send_frame(6, -1, -1, -1, 1'b1, -1, dp);
        send_frame(0, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (stat_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", stat_ovf); end
        n_cmp++; if (stat_edge_cnt !== CW'(2) || stat_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_keeps_first: got edge=%0d valid=%b want 2/1", stat_edge_cnt, stat_valid); end
        stat_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (stat_valid !== 1'b0 || stat_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_after_accept: got valid=%b ovf=%b want 0/0", stat_valid, stat_ovf); end
        repeat (2) @(negedge clk);
        n_cmp++; if (obs_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL ovf_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin n_bad++; $display("FAIL ovf_result: got e=%0d p=%0d err=%0d want e=%0d p=%0d err=%0d", o.e, o.p, o.err, e.e, e.p, e.err); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_run();
        int dp;
        pulse_cmd(1'b1, 1'b1, 1'b0);
        send_frame(9, -1, 77, 200, 1'b0, 2, dp);
        n_cmp++; if (busy !== 1'b1 || det_thr !== 11'd200) begin n_bad++; $display("FAIL rstmid_pre: got busy=%b thr=%0d want 1/200", busy, det_thr); end
        src_href = 1'b1;
        src_clken = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (det_href !== 1'b0 || det_clken !== 1'b0 || det_vsync !== 1'b0) begin n_bad++; $display("FAIL rstmid_det: got %b%b%b want 000", det_vsync, det_href, det_clken); end
        n_cmp++; if (det_thr !== 11'd450 || busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_state: got thr=%0d busy=%b want 450/0", det_thr, busy); end
        src_href = 1'b0;
        src_clken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (stat_valid !== 1'b0 || obs_q.size() !== 0) begin n_bad++; $display("FAIL rstmid_no_result: got valid=%b results=%0d want 0/0", stat_valid, obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_start_stop_same();
        int dp;
        pulse_cmd(1'b1, 1'b0, 1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL startstop_idle: got %b want 0", busy); end
        send_frame(3, -1, -1, -1, 1'b0, -1, dp);
        n_cmp++; if (dp !== 0 || obs_q.size() !== 0) begin n_bad++; $display("FAIL startstop_ungated: got pix=%0d results=%0d want 0/0", dp, obs_q.size()); end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_start = 1'b0; cmd_mode = 1'b0; cmd_stop = 1'b0;
        cfg_thr = '0; cfg_thr_wr = 1'b0;
        src_vsync = 1'b0; src_href = 1'b0; src_clken = 1'b0; src_edge = 1'b0;
        stat_ready = 1'b1;
        thr_mid_obs = '0;
        @(negedge clk);
        test_reset();
        test_single_shot();
        test_continuous_stop();
        test_threshold();
        test_geometry();
        test_overflow();
        test_reset_mid_run();
        test_start_stop_same();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_frame_scheduler.md
# edge_frame_scheduler

Frame-level controller for the Sobel edge-detection path. Sits between the camera sync stream and the edge detector and:
- admits whole frames into the detector in single-shot or continuous mode;
- applies threshold updates only at frame boundaries;
- counts edge pixels per frame on the detector output;
- returns per-frame statistics through a valid/ready handshake.

## Interface
- IMG_W, 640, active pixels per line
- IMG_H, 480, active lines per frame
- THR_DEFAULT, 450, threshold loaded at reset
- CNT_W, 20, statistic counter width (must hold IMG_W*IMG_H)

- clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_start  in  1  pulse; arm capture
- cmd_mode  in  1  sampled with cmd_start; 0 single-shot, 1 continuous
- cmd_stop  in  1  pulse; stop after current frame
- cfg_thr  in  11  new threshold
- cfg_thr_wr  in  1  pulse; load cfg_thr into shadow register
- src_vsync / src_href / src_clken  in  1 each  camera sync; vsync high pulse marks frame start
- det_vsync / det_href / det_clken  out  1 each  to detector
- det_thr  out  11  active threshold driven to detector
- edge_vsync / edge_href / edge_clken / edge_bit  in  1 each  detector output stream
- stat_valid  out  1  result available
- stat_ready  in  1  result consumed
- stat_edge_cnt  out  CNT_W  edge pixels in frame
- stat_pix_cnt  out  CNT_W  pixels counted in frame
- stat_err  out  1  frame geometry mismatch
- stat_ovf  out  1  sticky: a result was dropped
- busy  out  1  state != IDLE

## Operation
- Frame start (FS) = rising edge of src_vsync, detected against a 1-cycle delayed copy.
- Gate register `gate` changes only on the FS cycle.
- det_vsync = src_vsync, registered, never gated.
- det_href = src_href & gate, registered.
- det_clken = src_clken & gate, registered.
- Command arbitration:
  - cmd_stop and cmd_start in the same cycle: stop wins.
  - cmd_start outside IDLE: ignored.
- FSM:
  - IDLE: gate=0. cmd_start → ARMED; latch mode.
  - ARMED: cmd_stop → IDLE. On FS: gate←1, det_thr←shadow → RUN.
  - RUN: cmd_stop sets stop_pend. On FS:
    - if mode=0 or stop_pend: gate←0, clear stop_pend → DRAIN;
    - else: det_thr←shadow, stay RUN.
  - DRAIN: wait until the edge-side frame-done event → IDLE.
- Shadow threshold:
  - cfg_thr_wr loads it in any state.
  - det_thr never changes mid-frame.
  - Write coincident with FS: the new value is used in that frame.
- Edge-side counters (active while gated frames are in flight):
  - pix counts edge_href & edge_clken;
  - edge counts edge_href & edge_clken & edge_bit;
  - col counts pixels in the line;
  - line counts falling edges of edge_href.
- Line falling edge with col != IMG_W sets err.
- Frame done:
  - normal: line reaches IMG_H;
  - early: rising edge of edge_vsync with line != 0, which also sets err.
  - On frame done: snapshot results, clear counters.
- Result register:
  - Snapshot while stat_valid=0: load outputs, stat_valid←1.
  - Snapshot while stat_valid=1: result dropped, stat_ovf←1.
  - stat_valid falls on the cycle after stat_valid & stat_ready.
  - stat_ovf clears on the same accept.
- Counters saturate at 2^CNT_W−1.

## Timing
- Reset values:
  - det_* = 0;
  - det_thr = THR_DEFAULT;
  - stat_valid = stat_err = stat_ovf = 0;
  - stat counters = 0;
  - busy = 0;
  - FSM = IDLE.
- Reset mid-frame: immediate; the partial frame yields no result.
- src → det latency: 1 cycle.
- Gate and det_thr update in the FS cycle and take effect on the first det_href of that frame.
- stat_valid rises 1 cycle after the frame-done event.
- Vertical blanking must exceed detector latency (about 2 lines + 12 cycles); otherwise trailing pixels of a frame are attributed to the next frame.
- busy is combinational from the state register.

## Test plan
- Single-shot: IMG 8x4, cmd_start mode 0, one frame with edge_bit=1 on 5 pixels. Expect:
  - stat_valid once, edge_cnt=5, pix_cnt=32, err=0;
  - DRAIN→IDLE;
  - next frame not gated (det_href stays 0).
- Continuous with stop: cmd_start mode 1, 3 frames, cmd_stop mid frame 2. Expect:
  - frames 1 and 2 gated, frame 3 not gated;
  - two results;
  - busy low after frame 2 drains.
- Threshold timing: cfg_thr_wr=300 mid-RUN. Expect det_thr stays 450 until the next FS, then 300; write on the FS cycle takes effect immediately.
- Geometry error: one line of 7 pixels. Expect err=1 in the result, pix_cnt=31.
- Overflow: stat_ready=0 for 2 frames. Expect the first result held, stat_ovf=1; after accept, stat_valid=0 and stat_ovf=0.
- Reset/command corner:
  - rst_n low mid-RUN: all outputs return to reset values with no result.
  - cmd_start+cmd_stop in the same cycle from IDLE: stays IDLE.
